// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int CW              = 16,
  parameter int FW              = 8
) (
  input  logic          clk_25Mhz,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] H_Count_Value,
  output logic [CW-1:0] V_Count_Value,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so a sync pulse ending exactly at
  // 2^CW (zero back porch, full-width total) is still representable.
  localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_START  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_START  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          wrap_q, wrap_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic [CW:0]   h_ext;
  logic [CW:0]   v_ext;
  logic          hs_act;
  logic          vs_act;

  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  // Stage 0: raster counters, advancing only on enabled pixel clocks
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;
    wrap_d = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        wrap_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fc_d = fc_q + FW'(1);
        end else begin
          v_d  = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Stage 1: decode of the current count registers, loaded every clock
  always_comb begin
    hs_act        = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_act        = (v_ext >= VS_START) && (v_ext < VS_END);
    hsync_d       = hs_act ? ~SYNC_IDLE : SYNC_IDLE;
    vsync_d       = vs_act ? ~SYNC_IDLE : SYNC_IDLE;
    video_on_d    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    // wrap_q remembers that the last edge moved H from its final column to 0
    line_start_d  = wrap_q && (h_q == '0);
    frame_start_d = wrap_q && (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk_25Mhz) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      fc_q          <= '0;
      wrap_q        <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      fc_q          <= fc_d;
      wrap_q        <= wrap_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign H_Count_Value = h_q;
  assign V_Count_Value = v_q;
  assign frame_count   = fc_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign video_on      = video_on_q;
  assign line_start    = line_start_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: a default 640x480 instance and a tiny
// inverted-polarity instance, both compared against a pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;

  always #5 clk = ~clk;

  // Instance A: default timing
  logic [15:0] a_h, a_v;
  logic        a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [7:0]  a_fc;

  // Instance B: 7 x 6 raster, FW=2, active-high syncs
  logic [3:0]  b_h, b_v;
  logic        b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [1:0]  b_fc;

  vga_timing_gen dut_a (
    .clk_25Mhz(clk), .reset(reset), .pix_en(pix_en),
    .H_Count_Value(a_h), .V_Count_Value(a_v),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE_LOW(1'b0), .CW(4), .FW(2)
  ) dut_b (
    .clk_25Mhz(clk), .reset(reset), .pix_en(pix_en),
    .H_Count_Value(b_h), .V_Count_Value(b_v),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  int checks   = 0;
  int failures = 0;

  // Model: n counts enabled pixel clocks since the last reset; every raster
  // quantity is a plain arithmetic function of it.
  longint n        = 0;
  longint n_new    = 0;
  bit     adv_prev = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  task automatic check_inst(
    input string  p,
    input int     ha, input int hf, input int hsw, input int hb,
    input int     va, input int vf, input int vsw, input int vb,
    input int     fw, input bit al, input bit rs,
    input longint got_h, input longint got_v, input longint got_fc,
    input bit     got_hs, input bit got_vs, input bit got_vo,
    input bit     got_ls, input bit got_fs
  );
    longint ht, vt, hp, vp;
    bit     e_hs, e_vs, e_vo, e_ls, e_fs, hact, vact;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    check({p, "_h"},  got_h,  n_new % ht);
    check({p, "_v"},  got_v,  (n_new / ht) % vt);
    check({p, "_fc"}, got_fc, (n_new / (ht * vt)) % (64'd1 << fw));
    // Registered outputs reflect the raster position before this edge
    hp   = n % ht;
    vp   = (n / ht) % vt;
    hact = (hp >= ha + hf) && (hp < ha + hf + hsw);
    vact = (vp >= va + vf) && (vp < va + vf + vsw);
    e_hs = al ? !hact : hact;
    e_vs = al ? !vact : vact;
    e_vo = (hp < ha) && (vp < va);
    e_ls = adv_prev && (hp == 0);
    e_fs = e_ls && (vp == 0);
    if (rs) begin
      e_hs = al;
      e_vs = al;
      e_vo = 1'b0;
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
    check({p, "_hsync"},       got_hs, e_hs);
    check({p, "_vsync"},       got_vs, e_vs);
    check({p, "_video_on"},    got_vo, e_vo);
    check({p, "_line_start"},  got_ls, e_ls);
    check({p, "_frame_start"}, got_fs, e_fs);
  endtask

  task automatic step(input bit pe, input bit rs);
    pix_en = pe;
    reset  = rs;
    @(posedge clk);
    #1;
    n_new = rs ? 64'd0 : n + longint'(pe);
    check_inst("a", 640, 16, 96, 48, 480, 10, 2, 33, 8, 1'b1, rs,
               a_h, a_v, a_fc, a_hs, a_vs, a_vo, a_ls, a_fs);
    check_inst("b", 4, 1, 1, 1, 3, 1, 1, 1, 2, 1'b0, rs,
               b_h, b_v, b_fc, b_hs, b_vs, b_vo, b_ls, b_fs);
    n        = n_new;
    adv_prev = pe && !rs;
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Continuous enable: two default lines, dozens of small frames
    for (int i = 0; i < 1700; i++) step(1'b1, 1'b0);

    // Enable toggling every clock
    for (int i = 0; i < 3400; i++) step(i[0] == 1'b0, 1'b0);

    // Random enable with rare resets
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1999) == 0);

    // Mid-frame reset with the default raster at H=300, V=20
    step(1'b1, 1'b1);
    for (int i = 0; i < 800 * 20 + 300; i++) step(1'b1, 1'b0);
    check("mid_h_before", a_h, 300);
    step(1'b1, 1'b1);
    for (int i = 0; i < 900; i++) step(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
